bias_ram_loader: RTL and testbench
==================================

// Module: bias_ram_loader
// PURPOSE
//   Writer side of the layer-0 bias store. Receives a byte stream of Q8.8 biases,
//   assembles big-endian 16-bit words and writes them into a 256x16 on-chip RAM.
//   Exposes a registered read port so the layer engine can fetch biases by neuron index.
//   Lets biases be reloaded at run time without resynthesis.
// PARAMETERS
//   DEPTH  256  number of bias words (one per layer-0 neuron)
//   AW     8    address width, equal to clog2(DEPTH)
//   DW     16   bias word width, signed Q8.8
// PORTS
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      one-cycle pulse that begins a load; honoured in IDLE or DONE only
//   s_valid   in   1      byte stream valid
//   s_ready   out  1      byte stream ready
//   s_data    in   8      stream byte; high byte of each word first
//   rd_addr   in   AW     bias read address
//   rd_data   out  DW     signed bias; registered, 1-cycle latency
//   busy      out  1      a load is in progress
//   done      out  1      all DEPTH words written; held until the next start
//   err       out  1      checksum mismatch; sticky until the next start
//   word_cnt  out  AW+1   number of words written in the current load
// BEHAVIOUR
//   - Reset values: s_ready=0, busy=0, done=0, err=0, word_cnt=0, rd_data=0, state=IDLE.
//     RAM contents are not reset.
//   - Byte accepted only when s_valid && s_ready. s_data is sampled on that edge.
//   - FSM states: IDLE, HI, LO, CHK, DONE.
//     IDLE/DONE --start--> HI; also clears word_cnt, err, done and the checksum accumulator.
//     HI  --accept--> LO; latch hi_byte.
//     LO  --accept--> write mem[word_cnt[AW-1:0]] = {hi_byte, s_data}; word_cnt++.
//         Next state is CHK (or DONE) if word_cnt was DEPTH-1, otherwise HI.
//     CHK --accept--> DONE; err = ((sum + s_data) & 8'hFF) != 0.
//   - s_ready = 1 in HI, LO and CHK; 0 in IDLE and DONE. It is a registered decode of state.
//   - busy = (state is HI, LO or CHK). done = (state == DONE).
//   - start while busy is ignored. start in DONE restarts the load and drops done
//     on the next cycle.
//   - Write occurs on the LO accept edge. The new word is readable from the following cycle.
//   - Read: rd_data <= mem[rd_addr] every cycle.
//     Same-address read and write on the same edge returns the OLD word (read-first).
//   - No overflow: word_cnt saturates at DEPTH because s_ready drops.
//     Extra bytes stay unaccepted upstream.
//   - Reset mid-load returns to IDLE with done=0. Words already written stay in RAM.
//     A partial load is indicated only by done=0.
//   - Stalls (s_valid low) of any length in any state are legal and have no side effect.
// CONFIGURATION
//   BIAS_LOADER_CHECKSUM_EN defined:
//     - An 8-bit accumulator sums every data byte mod 256.
//     - After the last word, one trailer byte is accepted in CHK.
//     - err=1 if the data sum plus the trailer is nonzero mod 256.
//   BIAS_LOADER_CHECKSUM_EN undefined:
//     - No CHK state and no trailer byte; LO goes straight to DONE after the last word.
//     - err is tied to 0.
// STRUCTURE
//   kws_pkg (shared):
//     - typedef logic signed [15:0] q8_8_t
//     - localparam L0_NEURONS = 256
//     - typedef enum {IDLE, HI, LO, CHK, DONE} ldr_state_t
//   One sub-module: bias_dp_ram.
//     - 1 write port, 1 registered read port, read-first, no reset.
//     - Sized so it infers block RAM.
//   Top level holds the FSM, hi_byte register, word_cnt, checksum accumulator and output regs.
// TESTING
//   1. Reset then idle: s_valid=1 with start=0 -> s_ready=0, word_cnt=0, done=0 for 20 cycles.
//   2. Full load of 512 bytes, word i = 16'hFF00|i.
//      -> done=1 one cycle after the last accept; word_cnt=256.
//      -> Reading addr 0x87 returns 16'hFF87 one cycle after the address is applied.
//   3. Random s_valid gaps (30% idle) during a load
//      -> identical RAM contents to test 2; no byte lost or duplicated.
//   4. Reset asserted after 100 words -> IDLE, done=0.
//      -> Next start reloads from word 0; words 0..99 are readable before the reload overwrites them.
//   5. Read addr 5 on the same edge that writes addr 5 (old 16'h0000, new 16'hFFA4)
//      -> 16'h0000 first, then 16'hFFA4 on the following cycle.
//   6. With BIAS_LOADER_CHECKSUM_EN: correct trailer -> err=0, done=1.
//      Trailer+1 -> err=1, done=1. A start then clears err.

Source files
------------

// File: rtl/kws_pkg.sv
// kws_pkg: shared types and sizes for the keyword-spotting layer engine.
package kws_pkg;
   typedef logic signed [15:0] q8_8_t;
   localparam int L0_NEURONS = 256;
   typedef enum logic [2:0] {IDLE, HI, LO, CHK, DONE} ldr_state_t;
endpackage

// File: rtl/bias_dp_ram.sv
// bias_dp_ram: one write port, one registered read-first read port, contents never reset.
module bias_dp_ram #(
   parameter int DEPTH = 256,
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/bias_ram_loader.sv
// bias_ram_loader: byte-stream loader of Q8.8 biases into a 256x16 RAM with a registered read port.
// Optional trailer checksum when BIAS_LOADER_CHECKSUM_EN is defined.
module bias_ram_loader
   import kws_pkg::*;
#(
   parameter int DEPTH = L0_NEURONS,
   parameter int AW = $clog2(DEPTH),
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [7:0]           s_data,
   input  logic [AW-1:0]        rd_addr,
   output logic signed [DW-1:0] rd_data,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [AW:0]          word_cnt
);
`ifdef BIAS_LOADER_CHECKSUM_EN
   localparam ldr_state_t AFTER_LAST = CHK;
`else
   localparam ldr_state_t AFTER_LAST = DONE;
`endif
   ldr_state_t state, nxt;
   logic [7:0] hi_byte;
   logic [DW-1:0] ram_q;
   logic rd_ok;
   logic accept, last, restart;
   assign accept = s_valid & s_ready;
   assign last = word_cnt == (AW+1)'(DEPTH-1);
   assign restart = start & (state == IDLE || state == DONE);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         s_ready <= 1'b0;
      end else begin
         state <= nxt;
         s_ready <= nxt inside {HI, LO, CHK};
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE: nxt = start ? HI : state;
         HI:         nxt = accept ? LO : HI;
         LO:         nxt = accept ? (last ? AFTER_LAST : HI) : LO;
         CHK:        nxt = accept ? DONE : CHK;
         default:    nxt = IDLE;
      endcase
   end
   always_comb begin
      busy = state inside {HI, LO, CHK};
      done = state == DONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
         hi_byte <= '0;
         rd_ok <= 1'b0;
      end else begin
         rd_ok <= 1'b1;
         if (restart) word_cnt <= '0;
         if (accept && state == HI) hi_byte <= s_data;
         if (accept && state == LO) word_cnt <= word_cnt + (AW+1)'(1);
      end
   end
`ifdef BIAS_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   logic err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
         err_q <= 1'b0;
      end else begin
         if (restart) begin
            sum <= '0;
            err_q <= 1'b0;
         end
         if (accept && state != CHK) sum <= sum + s_data;
         if (accept && state == CHK) err_q <= (sum + s_data) != 8'd0;
      end
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif
   bias_dp_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
      .clk   (clk),
      .we    (accept && state == LO),
      .waddr (word_cnt[AW-1:0]),
      .wdata ({hi_byte, s_data}),
      .raddr (rd_addr),
      .rdata (ram_q)
   );
   // RAM output register has no reset, so hold rd_data at zero until it has been clocked once
   assign rd_data = rd_ok ? ram_q : '0;
endmodule

// File: tb/tb_bias_ram_loader.sv
// tb_bias_ram_loader: directed self-checking bench with a read scoreboard.
module tb_bias_ram_loader;
   logic clk = 1'b0;
   logic rst_n, start, s_valid, s_ready, busy, done, err;
   logic [7:0] s_data, rd_addr;
   logic [15:0] rd_data;
   logic [8:0] word_cnt;
   logic [15:0] exp_mem [256];
   logic [15:0] sbq [$];
   logic [7:0] csum;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   bias_ram_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
      .err(err), .word_cnt(word_cnt)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit acc = 1'b0;
      if (gaps && $urandom_range(0, 99) < 30) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data = b;
      for (int n = 0; n < 200 && !acc; n++) begin
         acc = s_ready;
         @(negedge clk);
      end
      s_valid = 1'b0;
      if (!acc) check("send_timeout", {31'd0, acc}, 32'd1);
      csum = csum + b;
   endtask
   task automatic send_word(input logic [15:0] w, input bit gaps);
      send_byte(w[15:8], gaps);
      send_byte(w[7:0], gaps);
   endtask
   task automatic pulse_start;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      csum = 8'd0;
   endtask
   task automatic finish_load(input bit bad);
`ifdef BIAS_LOADER_CHECKSUM_EN
      logic [7:0] t;
      t = 8'd0 - csum + {7'd0, bad};
      send_byte(t, 1'b0);
`else
      if (bad) @(negedge clk);
`endif
   endtask
   task automatic full_load(input bit gaps, input bit bad);
      pulse_start();
      for (int i = 0; i < 256; i++) send_word(exp_mem[i], gaps);
      finish_load(bad);
   endtask
   task automatic rd_chk(input int a);
      rd_addr = a[7:0];
      sbq.push_back(exp_mem[a]);
      @(negedge clk);
      check($sformatf("rd_%0h", a), {16'd0, rd_data}, {16'd0, sbq.pop_front()});
   endtask
   task automatic rd_all;
      for (int a = 0; a < 256; a++) rd_chk(a);
   endtask
   initial begin
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'd0; rd_addr = 8'd0; csum = 8'd0;
      @(negedge clk);
      check("rst_ready", {31'd0, s_ready}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_err", {31'd0, err}, 0);
      check("rst_cnt", {23'd0, word_cnt}, 0);
      check("rst_rd", {16'd0, rd_data}, 0);
      rst_n = 1'b1;
      // 1: idle with valid high, nothing accepted
      s_valid = 1'b1;
      s_data = 8'hA5;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_ready", {31'd0, s_ready}, 0);
         check("idle_cnt", {23'd0, word_cnt}, 0);
         check("idle_done", {31'd0, done}, 0);
      end
      s_valid = 1'b0;
      // 2: full load, word i = FF00|i
      for (int i = 0; i < 256; i++) exp_mem[i] = 16'hFF00 | 16'(i);
      full_load(1'b0, 1'b0);
      check("t2_done", {31'd0, done}, 1);
      check("t2_busy", {31'd0, busy}, 0);
      check("t2_cnt", {23'd0, word_cnt}, 256);
      check("t2_err", {31'd0, err}, 0);
      rd_chk(8'h87);
      s_valid = 1'b1;
      s_data = 8'h55;
      repeat (5) @(negedge clk);
      check("ovf_cnt", {23'd0, word_cnt}, 256);
      check("ovf_ready", {31'd0, s_ready}, 0);
      s_valid = 1'b0;
      rd_all();
      // 3: random gaps and an ignored start mid-load
      for (int i = 0; i < 256; i++) exp_mem[i] = 16'h3C00 ^ 16'(i * 7);
      pulse_start();
      check("rs_done", {31'd0, done}, 0);
      check("rs_busy", {31'd0, busy}, 1);
      check("rs_cnt", {23'd0, word_cnt}, 0);
      for (int i = 0; i < 10; i++) send_word(exp_mem[i], 1'b1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_start_cnt", {23'd0, word_cnt}, 10);
      check("busy_start_busy", {31'd0, busy}, 1);
      for (int i = 10; i < 256; i++) send_word(exp_mem[i], 1'b1);
      finish_load(1'b0);
      check("t3_done", {31'd0, done}, 1);
      check("t3_cnt", {23'd0, word_cnt}, 256);
      for (int i = 0; i < 256; i++) exp_mem[i] = 16'hFF00 | 16'(i);
      full_load(1'b1, 1'b0);
      check("t3b_done", {31'd0, done}, 1);
      rd_all();
      // 4: reset after 100 words of a partial load
      pulse_start();
      for (int i = 0; i < 100; i++) begin
         exp_mem[i] = (i == 5) ? 16'h0000 : 16'h1200 + 16'(i);
         send_word(exp_mem[i], 1'b0);
      end
      check("t4_cnt_pre", {23'd0, word_cnt}, 100);
      rst_n = 1'b0;
      #1;
      check("t4_done", {31'd0, done}, 0);
      check("t4_busy", {31'd0, busy}, 0);
      check("t4_ready", {31'd0, s_ready}, 0);
      check("t4_cnt", {23'd0, word_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t4_idle_done", {31'd0, done}, 0);
      rd_all();
      // 5: reload; read-first collision on address 5
      for (int i = 0; i < 256; i++) exp_mem[i] = (i == 5) ? 16'hFFA4 : 16'hFF00 | 16'(i);
      rd_addr = 8'd5;
      pulse_start();
      check("t5_cnt", {23'd0, word_cnt}, 0);
      for (int i = 0; i < 256; i++) begin
         send_word(exp_mem[i], 1'b0);
         if (i == 5) begin
            check("rf_old", {16'd0, rd_data}, 32'h0000);
            @(negedge clk);
            check("rf_new", {16'd0, rd_data}, 32'hFFA4);
         end
      end
      finish_load(1'b0);
      check("t5_done", {31'd0, done}, 1);
      rd_all();
`ifdef BIAS_LOADER_CHECKSUM_EN
      // 6: bad trailer sets err, next start clears it
      full_load(1'b0, 1'b1);
      check("t6_err", {31'd0, err}, 1);
      check("t6_done", {31'd0, done}, 1);
      pulse_start();
      check("t6_clr_err", {31'd0, err}, 0);
      check("t6_clr_done", {31'd0, done}, 0);
      for (int i = 0; i < 256; i++) send_word(exp_mem[i], 1'b0);
      finish_load(1'b0);
      check("t6_ok_err", {31'd0, err}, 0);
      check("t6_ok_done", {31'd0, done}, 1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
